// File: rtl/fir_tdm_pkg.sv
// Shared constants and state encoding for the time-multiplexed symmetric FIR.
// FIR_ROUND_EN selects round-half-up output by preloading the accumulator.
package fir_tdm_pkg;

   localparam int H0 = -1495;
   localparam int H1 = -942;
   localparam int H2 = 9687;
   localparam int H3 = 18269;

   localparam int ACCW_DEF = 24;
   localparam int Q_SHIFT  = 14;
   localparam int RND      = 1 << (Q_SHIFT - 1);

`ifdef FIR_ROUND_EN
   localparam int ACC_INIT = RND;
`else
   localparam int ACC_INIT = 0;
`endif

   typedef enum logic [2:0] {
      IDLE,
      MAC0,
      MAC1,
      MAC2,
      MAC3,
      OUT
   } state_t;

endpackage

// File: rtl/fir_sym_mac.sv
// Shared pre-add / constant-multiply / accumulate datapath for the 7-tap symmetric FIR.
// Coefficients are fixed, so the products are built from shift-add trees rather than a multiplier.
module fir_sym_mac
   import fir_tdm_pkg::*;
#(
   parameter int DW   = 8,
   parameter int ACCW = ACCW_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [DW-1:0]   a,
   input  logic signed [DW-1:0]   b,
   input  logic        [1:0]      sel,
   input  logic                   clr,
   input  logic                   en,
   output logic signed [ACCW-1:0] acc
);

   logic signed [DW:0]     pre;
   logic signed [ACCW-1:0] pre_x;
   logic signed [ACCW-1:0] prod;

   function automatic logic signed [ACCW-1:0] cmul(input logic signed [ACCW-1:0] x,
                                                   input int c);
      logic signed [ACCW-1:0] sum;
      int                     mag;
      sum = '0;
      mag = (c < 0) ? -c : c;
      for (int i = 0; i < 16; i++) begin
         if (mag[i]) sum = sum + (x <<< i);
      end
      return (c < 0) ? -sum : sum;
   endfunction

   // Both taps are sign-extended before the add so the pre-add cannot wrap.
   assign pre   = (DW+1)'(a) + (DW+1)'(b);
   assign pre_x = ACCW'(pre);

   always_comb begin
      prod = '0;
      case (sel)
         2'd0:    prod = cmul(pre_x, H0);
         2'd1:    prod = cmul(pre_x, H1);
         2'd2:    prod = cmul(pre_x, H2);
         default: prod = cmul(pre_x, H3);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (clr)
         acc <= ACCW'(ACC_INIT);
      else if (en)
         acc <= acc + prod;
   end

endmodule

// File: rtl/fir_tdm_scheduler.sv
// NCH-channel 7-tap symmetric low-pass FIR sharing one MAC: round-robin input arbiter,
// per-channel delay lines, sequencer FSM and tagged result port. Rounding via FIR_ROUND_EN.
//
// state | meaning
// IDLE  | offer round-robin grant, accept one sample, clear accumulator
// MAC0  | acc += H0*(d0+d6)
// MAC1  | acc += H1*(d1+d5)
// MAC2  | acc += H2*(d2+d4)
// MAC3  | acc += H3*d3
// OUT   | present result until m_ready
module fir_tdm_scheduler
   import fir_tdm_pkg::*;
#(
   parameter  int NCH  = 4,
   parameter  int DW   = 8,
   parameter  int ACCW = ACCW_DEF,
   parameter  int OW   = 10,
   localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        s_valid,
   input  logic [NCH*DW-1:0]     s_data,
   output logic [NCH-1:0]        s_ready,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic signed [OW-1:0]  m_data,
   output logic [CW-1:0]         m_chan,
   output logic                  busy
);

   state_t state, state_nxt;

   logic [CW-1:0]        ptr;
   logic [CW-1:0]        chan;
   logic [CW-1:0]        grant;
   logic [NCH-1:0]       grant_oh;
   logic                 found;
   logic                 accept;

   logic signed [DW-1:0] dl [NCH][7];

   logic signed [DW-1:0]   op_a, op_b;
   logic        [1:0]      sel;
   logic                   mac_en;
   logic signed [ACCW-1:0] acc;

   // Search starts one past the last winner so every requester is served in turn.
   always_comb begin
      int idx;
      idx      = 0;
      grant    = '0;
      found    = 1'b0;
      grant_oh = '0;
      for (int i = 1; i <= NCH; i++) begin
         idx = (int'(ptr) + i) % NCH;
         if (!found && s_valid[idx]) begin
            found = 1'b1;
            grant = CW'(idx);
         end
      end
      if (found) grant_oh[grant] = 1'b1;
   end

   assign s_ready = (state == IDLE && !rst) ? grant_oh : '0;
   assign accept  = (state == IDLE) && found;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= CW'(NCH - 1);
         chan  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            ptr  <= grant;
            chan <= grant;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int n = 0; n < NCH; n++)
            for (int k = 0; k < 7; k++)
               dl[n][k] <= '0;
      end else if (accept) begin
         dl[grant][0] <= s_data[int'(grant)*DW +: DW];
         for (int k = 1; k < 7; k++)
            dl[grant][k] <= dl[grant][k-1];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = MAC0;
         MAC0:    state_nxt = MAC1;
         MAC1:    state_nxt = MAC2;
         MAC2:    state_nxt = MAC3;
         MAC3:    state_nxt = OUT;
         OUT:     if (m_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Symmetric taps pair up; the centre tap goes alone with a zero partner.
   always_comb begin
      op_a   = '0;
      op_b   = '0;
      sel    = 2'd0;
      mac_en = 1'b0;
      case (state)
         MAC0: begin
            op_a   = dl[chan][0];
            op_b   = dl[chan][6];
            sel    = 2'd0;
            mac_en = 1'b1;
         end
         MAC1: begin
            op_a   = dl[chan][1];
            op_b   = dl[chan][5];
            sel    = 2'd1;
            mac_en = 1'b1;
         end
         MAC2: begin
            op_a   = dl[chan][2];
            op_b   = dl[chan][4];
            sel    = 2'd2;
            mac_en = 1'b1;
         end
         MAC3: begin
            op_a   = dl[chan][3];
            op_b   = '0;
            sel    = 2'd3;
            mac_en = 1'b1;
         end
         default: ;
      endcase
   end

   fir_sym_mac #(
      .DW   (DW),
      .ACCW (ACCW)
   ) u_mac (
      .clk (clk),
      .rst (rst),
      .a   (op_a),
      .b   (op_b),
      .sel (sel),
      .clr (accept),
      .en  (mac_en),
      .acc (acc)
   );

   // Accumulator is frozen in OUT, so the result slice is stable until the handshake.
   assign m_valid = (state == OUT);
   assign m_data  = acc[ACCW-1 -: OW];
   assign m_chan  = chan;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Bench for fir_tdm_scheduler: vector table, hand-written corner sequences and a
// convolution-level reference model fed by random traffic. Honours FIR_ROUND_EN.
module tb_fir_tdm_scheduler;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int OW  = 10;
   localparam int CW  = 2;

`ifdef FIR_ROUND_EN
   localparam int RND_B = 8192;
`else
   localparam int RND_B = 0;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NCH-1:0]       s_valid = '0;
   logic [NCH*DW-1:0]    s_data = '0;
   logic [NCH-1:0]       s_ready;
   logic                 m_valid;
   logic                 m_ready = 1'b0;
   logic signed [OW-1:0] m_data;
   logic [CW-1:0]        m_chan;
   logic                 busy;

   int n_chk  = 0;
   int n_fail = 0;

   int hb [7] = '{-1495, -942, 9687, 18269, 9687, -942, -1495};

   fir_tdm_scheduler #(.NCH(NCH), .DW(DW), .ACCW(24), .OW(OW)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_data  (s_data),
      .s_ready (s_ready),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_chan  (m_chan),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: per-channel sample history and direct convolution.
   int m_hist [NCH][7];
   int m_ptr, m_ch, m_y, m_acc_cyc, ncyc, sel_ch, mi, acc_m;
   bit m_pend, m_f, emv;
   logic [NCH-1:0] er;

   always @(negedge clk) begin
      if (rst) begin
         for (int n = 0; n < NCH; n++)
            for (int k = 0; k < 7; k++) m_hist[n][k] = 0;
         m_ptr  = NCH - 1;
         m_pend = 1'b0;
         ncyc   = 0;
      end else begin
         er = '0; m_f = 1'b0; sel_ch = 0;
         if (!m_pend) begin
            for (int i = 1; i <= NCH; i++) begin
               mi = (m_ptr + i) % NCH;
               if (!m_f && s_valid[mi]) begin
                  m_f = 1'b1; er[mi] = 1'b1; sel_ch = mi;
               end
            end
         end
         emv = m_pend && (ncyc - m_acc_cyc >= 5);
         chk("mon_s_ready", int'(s_ready), int'(er));
         chk("mon_busy", int'(busy), int'(m_pend));
         chk("mon_m_valid", int'(m_valid), int'(emv));
         if (emv) begin
            chk("mon_m_data", int'(m_data), m_y);
            chk("mon_m_chan", int'(m_chan), m_ch);
         end
         if (m_f) begin
            for (int k = 6; k > 0; k--) m_hist[sel_ch][k] = m_hist[sel_ch][k-1];
            m_hist[sel_ch][0] = int'($signed(s_data[sel_ch*DW +: DW]));
            acc_m = RND_B;
            for (int k = 0; k < 7; k++) acc_m += hb[k] * m_hist[sel_ch][k];
            m_y       = acc_m >>> 14;
            m_ch      = sel_ch;
            m_ptr     = sel_ch;
            m_pend    = 1'b1;
            m_acc_cyc = ncyc;
         end else if (emv && m_ready) begin
            m_pend = 1'b0;
         end
         ncyc++;
      end
   end

   // Entered and left at posedge+1.
   task automatic send(input int ch, input int x, input int exp_y, input bit do_chk);
      int n;
      s_data[ch*DW +: DW] = DW'(x);
      s_valid     = '0;
      s_valid[ch] = 1'b1;
      m_ready     = 1'b1;
      #1;
      n = 0;
      while (!s_ready[ch] && n < 20) begin
         @(posedge clk); #2; n++;
      end
      chk("send_grant", int'(s_ready[ch]), 1);
      @(posedge clk); #1;
      s_valid = '0;
      n = 0;
      while (!m_valid && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("send_m_valid", int'(m_valid), 1);
      if (do_chk) begin
         chk("send_m_data", int'(m_data), exp_y);
         chk("send_m_chan", int'(m_chan), ch);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 40) begin
         @(posedge clk); #1; n++;
      end
      chk("wait_idle", int'(busy), 0);
   endtask

   typedef struct {
      int ch;
      int x;
      int y;
   } vec_t;

   vec_t tbl [22];

   initial begin
      int exp_g, prev, ng, part, held_d, held_c;

`ifdef FIR_ROUND_EN
      int imp0 [8] = '{-12, -7, 75, 142, 75, -7, -12, 0};
      int imp2 [7] = '{-9, -6, 59, 112, 59, -6, -9};
`else
      int imp0 [8] = '{-12, -8, 75, 141, 75, -8, -12, 0};
      int imp2 [7] = '{-10, -6, 59, 111, 59, -6, -10};
`endif
      for (int i = 0; i < 8; i++) tbl[i] = '{0, (i == 0) ? 127 : 0, imp0[i]};
      for (int i = 0; i < 7; i++) begin
         tbl[8 + 2*i]     = '{2, (i == 0) ? 100 : 0, imp2[i]};
         tbl[8 + 2*i + 1] = '{3, 0, 0};
      end

      // Reset values, with every requester asserted.
      s_valid = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_m_chan", int'(m_chan), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_s_ready", int'(s_ready), 0);
      s_valid = '0;
      rst     = 1'b0;

      repeat (5) @(posedge clk);
      #1;
      chk("idle_no_valid_busy", int'(busy), 0);

      for (int i = 0; i < 22; i++) send(tbl[i].ch, tbl[i].x, tbl[i].y, 1'b1);

      // DC on ch1: expected output is the running coefficient sum times the level.
      part = 0;
      for (int i = 0; i < 10; i++) begin
         if (i < 7) part += hb[i];
         send(1, -128, (part * -128 + RND_B) >>> 14, 1'b1);
      end

      // All requesters high: strict rotation, one accept every 6 clocks.
      s_valid = '1;
      m_ready = 1'b1;
      exp_g   = 2;
      prev    = -1;
      ng      = 0;
      for (int cyc = 0; cyc < 80 && ng < 8; cyc++) begin
         #1;
         if (s_ready != 0) begin
            chk("rr_grant", int'(s_ready), 1 << exp_g);
            if (prev >= 0) chk("rr_period", cyc - prev, 6);
            prev  = cyc;
            exp_g = (exp_g + 1) % NCH;
            ng++;
         end
         @(posedge clk); #1;
      end
      chk("rr_count", ng, 8);
      s_valid = '0;
      wait_idle();

      // Backpressure: result held in OUT, nothing accepted.
      s_valid = '1;
      m_ready = 1'b0;
      #1;
      chk("hold_grant", int'(s_ready), 1 << 2);
      @(posedge clk); #1;
      ng = 0;
      while (!m_valid && ng < 20) begin
         @(posedge clk); #1; ng++;
      end
      held_d = int'(m_data);
      held_c = int'(m_chan);
      chk("hold_chan", held_c, 2);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("hold_m_valid", int'(m_valid), 1);
         chk("hold_m_data", int'(m_data), held_d);
         chk("hold_s_ready", int'(s_ready), 0);
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_grant", int'(s_ready), 1 << 3);
      @(posedge clk); #1;
      s_valid = '0;
      wait_idle();

      // Reset while the sequencer is in MAC2.
      s_data[0 +: DW] = 8'd50;
      s_valid = 4'b0001;
      #1;
      chk("mid_rst_grant", int'(s_ready), 1);
      @(posedge clk); #1;
      s_valid = '0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_rst_busy_before", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_m_valid", int'(m_valid), 0);
      chk("mid_rst_m_data", int'(m_data), 0);
      chk("mid_rst_m_chan", int'(m_chan), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      s_valid = '1;
      #1;
      chk("post_rst_first_grant", int'(s_ready), 1);
      s_valid = '0;
      send(0, 127, imp0[0], 1'b1);

      // Random traffic against the reference model.
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         s_valid = NCH'($urandom);
         s_data  = NCH*DW'($urandom);
         m_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      s_valid = '0;
      m_ready = 1'b1;
      wait_idle();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
